// File: rtl/battleship_board.sv
// battleship_board: N x N Battleship board-state engine.
// Owns ship/shot matrices, places ships, scores shots.
//
// Params : N (board side, 2..16), MAX_SHOTS (shot budget)
// Inputs : clk, rst (async, active-high), clear,
//          place_valid/place_row/place_col, start,
//          fire_valid/fire_row/fire_col
// Outputs: fire_ready, result_valid/hit/repeat/oob,
//          matriz_barcos (N*N), matriz_disparos (2*N*N),
//          ships_left, game_over, game_lost
// Option : BOARD_SHOT_LIMIT_EN enables the MAX_SHOTS budget.
module battleship_board #(
  parameter int N         = 5,
  parameter int MAX_SHOTS = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       place_valid,
  input  logic [$clog2(N)-1:0]       place_row,
  input  logic [$clog2(N)-1:0]       place_col,
  input  logic                       start,
  input  logic                       fire_valid,
  output logic                       fire_ready,
  input  logic [$clog2(N)-1:0]       fire_row,
  input  logic [$clog2(N)-1:0]       fire_col,
  output logic                       result_valid,
  output logic                       result_hit,
  output logic                       result_repeat,
  output logic                       result_oob,
  output logic [N*N-1:0]             matriz_barcos,
  output logic [2*N*N-1:0]           matriz_disparos,
  output logic [$clog2(N*N+1)-1:0]   ships_left,
  output logic                       game_over,
  output logic                       game_lost
);

  localparam int IW = $clog2(N*N);
  localparam int CW = $clog2(N*N+1);

  typedef enum logic [1:0] {
    SETUP = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic          p_in;
  logic [IW-1:0] p_idx;
  logic          p_ok;

  logic          fire_acc;
  logic          f_in;
  logic [IW-1:0] f_idx;
  logic [1:0]    f_code;
  logic          f_ship;
  logic          f_new;
  logic          f_hit;
  logic          sink;
  logic          lose;

  assign fire_ready = (state_q == PLAY);

  // Placement decode
  assign p_in  = (32'(place_row) < N) &&
                 (32'(place_col) < N);
  assign p_idx = IW'(32'(place_row) * N +
                     32'(place_col));
  assign p_ok  = (state_q == SETUP) && place_valid &&
                 p_in && !matriz_barcos[p_idx];

  // Shot decode; reads are gated so an off-board
  // coordinate never indexes past the matrices
  assign fire_acc = fire_valid && fire_ready && !clear;
  assign f_in  = (32'(fire_row) < N) &&
                 (32'(fire_col) < N);
  assign f_idx = IW'(32'(fire_row) * N +
                     32'(fire_col));
  assign f_code = f_in ?
    matriz_disparos[{f_idx, 1'b0} +: 2] : 2'd0;
  assign f_ship = f_in && matriz_barcos[f_idx];
  assign f_new  = f_in && (f_code == 2'd0);
  assign f_hit  = f_new && f_ship;
  assign sink   = fire_acc && f_hit &&
                  (ships_left == CW'(1));

`ifdef BOARD_SHOT_LIMIT_EN
  localparam int SW = $clog2(MAX_SHOTS+1);

  logic [SW-1:0] shots_taken;

  // A sinking shot takes precedence over the budget
  assign lose = fire_acc && f_new && !sink &&
                (32'(shots_taken) + 1 == MAX_SHOTS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shots_taken <= '0;
      game_lost   <= 1'b0;
    end else if (clear) begin
      shots_taken <= '0;
      game_lost   <= 1'b0;
    end else if (fire_acc && f_new) begin
      shots_taken <= shots_taken + SW'(1);
      if (lose)
        game_lost <= 1'b1;
    end
  end
`else
  logic unused_max_shots;

  assign unused_max_shots = (MAX_SHOTS != 0);
  assign lose      = 1'b0;
  assign game_lost = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= SETUP;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = SETUP;
    end else begin
      unique case (state_q)
        SETUP:
          if (start && (ships_left != '0))
            state_d = PLAY;
        PLAY:
          if (sink || lose)
            state_d = OVER;
        OVER:
          state_d = OVER;
        default:
          state_d = SETUP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      matriz_barcos   <= '0;
      matriz_disparos <= '0;
      ships_left      <= '0;
      result_valid    <= 1'b0;
      result_hit      <= 1'b0;
      result_repeat   <= 1'b0;
      result_oob      <= 1'b0;
      game_over       <= 1'b0;
    end else if (clear) begin
      matriz_barcos   <= '0;
      matriz_disparos <= '0;
      ships_left      <= '0;
      result_valid    <= 1'b0;
      result_hit      <= 1'b0;
      result_repeat   <= 1'b0;
      result_oob      <= 1'b0;
      game_over       <= 1'b0;
    end else begin
      result_valid  <= fire_acc;
      result_hit    <= 1'b0;
      result_repeat <= 1'b0;
      result_oob    <= 1'b0;
      if (p_ok) begin
        matriz_barcos[p_idx] <= 1'b1;
        ships_left <= ships_left + CW'(1);
      end
      if (fire_acc) begin
        result_oob    <= !f_in;
        result_repeat <= f_in && !f_new;
        result_hit    <= f_new ? f_ship :
                         (f_code == 2'd2);
        if (f_new) begin
          matriz_disparos[{f_idx, 1'b0} +: 2] <=
            f_ship ? 2'd2 : 2'd1;
          if (f_ship)
            ships_left <= ships_left - CW'(1);
        end
        if (sink)
          game_over <= 1'b1;
      end
    end
  end

endmodule

// File: doc/battleship_board.md
# battleship_board

Parametrised N×N Battleship board-state engine that owns the ship, hit and shot matrices as registers instead of constants. Ships are placed during a setup phase. Shots are then accepted over a valid/ready handshake, classified as hit, miss, repeat or out-of-range, and the matrices are updated. Remaining ship cells are counted and game end is detected. Its flattened matrix outputs feed the existing `vga` renderer one level down from the top-level game module.

## Interface
- `N`, default 5: board side; legal range 2–16.
- `MAX_SHOTS`, default 15: shot budget; used only with `BOARD_SHOT_LIMIT_EN`.
- `clk` in, 1: system clock.
- `rst` in, 1: asynchronous, active-high reset.
- `clear` in, 1: synchronous return to SETUP with all matrices zeroed.
- `place_valid` in, 1: set the ship bit at `place_row`/`place_col`.
- `place_row`, `place_col` in, `$clog2(N)`: placement coordinate.
- `start` in, 1: leave SETUP and enter PLAY.
- `fire_valid` in, 1: shot request.
- `fire_ready` out, 1: shot can be accepted.
- `fire_row`, `fire_col` in, `$clog2(N)`: shot coordinate.
- `result_valid` out, 1: one-cycle result pulse.
- `result_hit`, `result_repeat`, `result_oob` out, 1 each: classification of the shot.
- `matriz_barcos` out, `N*N`: ship bits; index `r*N+c`.
- `matriz_disparos` out, `2*N*N`: shot codes at bits `[2(r*N+c)+1 : 2(r*N+c)]`; 0 = none, 1 = miss, 2 = hit.
- `ships_left` out, `$clog2(N*N+1)`: unhit ship cells.
- `game_over` out, 1: all ships sunk.
- `game_lost` out, 1: shot budget exhausted (always 0 without the macro).

## Operation
- FSM states: SETUP, PLAY, OVER. Reset state is SETUP.
- SETUP:
  - `place_valid` with an in-range coordinate whose ship bit is 0 sets the bit and increments `ships_left`.
  - Placing on an occupied cell or an out-of-range coordinate does nothing.
  - `start` with `ships_left > 0` moves to PLAY.
  - `start` with `ships_left == 0` is ignored.
  - `fire_valid` is ignored.
- PLAY:
  - `fire_ready = 1`. A shot is accepted when `fire_valid && fire_ready`.
  - If either coordinate is ≥ N: `result_oob = 1`. No matrix change and no counting.
  - If the cell's shot code ≠ 0: `result_repeat = 1`; `result_hit` reflects the stored code. No change, no counting.
  - Otherwise, if the ship bit is 1: write code 2, `result_hit = 1`, decrement `ships_left`.
  - Otherwise: write code 1, `result_hit = 0`.
  - `place_valid` and `start` are ignored.
- Transition to OVER:
  - A hit that takes `ships_left` from 1 to 0 → OVER, `game_over = 1`.
  - With the macro, a counted shot that makes `shots_taken == MAX_SHOTS` while `ships_left > 0` after the update → OVER, `game_lost = 1`.
  - If both conditions hold on the same shot, `game_over` wins and `game_lost` stays 0.
- OVER:
  - `fire_ready = 0`. Matrices and flags hold.
  - Only `clear` or `rst` leaves OVER.
- `clear` (any state) has priority over place, start and fire in the same cycle. It zeroes all matrices, counters and flags and goes to SETUP. No `result_valid` is generated for a shot presented in that cycle.
- Reset values: all matrices 0, `ships_left = 0`, `fire_ready = 0`, `result_*` = 0, `game_over = 0`, `game_lost = 0`, state SETUP.

## Timing
- Placement: ship bit and `ships_left` update on the clock edge after `place_valid` is sampled.
- Fire latency is 1: a shot accepted at edge k produces `result_valid` high for exactly the cycle after edge k, with the matrix update visible in that same cycle.
- Back-to-back shots every cycle are legal. A second shot to the same cell on the next cycle sees the updated code and reports `result_repeat = 1`; no forwarding hazard is allowed.
- `fire_ready` drops in the cycle after the accepting edge that enters OVER.
- `start` takes effect at the next edge: `fire_ready` rises one cycle after `start` is sampled.
- `rst` asserted mid-operation clears every output asynchronously, including a pending `result_valid`.

## Configuration
- `BOARD_SHOT_LIMIT_EN` defined:
  - An internal `shots_taken` counter of width `$clog2(MAX_SHOTS+1)` counts non-repeat, in-range shots.
  - The loss condition is active.
- Not defined:
  - No counter is instantiated.
  - `game_lost` is tied to 0 and play is unlimited.

## Test plan
- N=5: place (0,0), (0,1), (4,4); `start`; fire (0,0) → next cycle `result_hit = 1`, shot code[0] = 2, `ships_left = 2`.
- Fire (2,2) on water → code 1, `result_hit = 0`. Fire (2,2) on the next cycle → `result_repeat = 1`, `ships_left` unchanged.
- Fire (5,0) → `result_oob = 1`, no matrix change. `start` with no ships placed → state stays SETUP, `fire_ready = 0`.
- Sink all 3 ship cells → `game_over = 1`, `fire_ready = 0`; further `fire_valid` produces no `result_valid`. Then `clear` → all outputs 0, SETUP.
- Macro on, `MAX_SHOTS = 2`, one ship: two misses → `game_lost = 1`. Alternative run: miss then sink the ship on the last shot → `game_over = 1`, `game_lost = 0`.
- Assert `rst` in the cycle `result_valid` is due → `result_valid` stays 0 and all matrices read 0.
